sd_card_dat_responder: RTL and testbench

Card-side responder for the SD DAT0 line in 1-bit bus mode. It is the other end of the host data path and is used as the bench/behavioural card for the SD host. On a read it sources one block from a word memory and serialises it with start bit, CRC16 and end bit. On a write it deserialises one block into the word memory, checks CRC16, returns the CRC status token and holds DAT0 busy.

---
 rtl/sd_card_dat_responder.sv | 259 +++++++++++++++++++++++++
 tb/tb_sd_card_dat_responder.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sd_card_dat_responder.sv
// rtl/sd_card_dat_responder.sv - card-side SD DAT0 responder, 1-bit bus mode
//
// Behavioural card for the SD host data path. A read serialises one block
// from the word memory. The serial frame is NAC idle-high cycles, a start bit,
// the data bits MSB first, CRC16, and an end bit. A write deserialises one
// block into the word memory, checks its CRC16 and end bit, and returns the
// CRC status token. A good write then holds DAT0 busy.
//
// Ports:
//   iClock, iReset        clock (rising edge), synchronous active-high reset
//   iStartRead            transmit one block (sampled in IDLE, wins over write)
//   iStartWrite           arm reception of one block (sampled in IDLE)
//   iAbort                abandon the current transfer, back to IDLE
//   iDat                  DAT0 as driven by the host
//   oDat, oDatOe          DAT0 value and enable driven by the card
//   oMemAddr              word index within the block
//   iMemRdata             word at oMemAddr (combinational memory read)
//   oMemWdata, oMemWe     received word and its one-cycle write strobe
//   oBusy                 high while not in IDLE
//   oDone                 one-cycle pulse at the normal end of a transfer
//   oCrcError             sticky CRC/end-bit error of the last write
module sd_card_dat_responder #(
   parameter int DATA_WORDS  = 16,
   parameter int BUSY_CYCLES = 8,
   parameter int NAC_CYCLES  = 2
) (
   input  logic        iClock,
   input  logic        iReset,
   input  logic        iStartRead,
   input  logic        iStartWrite,
   input  logic        iAbort,
   input  logic        iDat,
   output logic        oDat,
   output logic        oDatOe,
   output logic [7:0]  oMemAddr,
   input  logic [31:0] iMemRdata,
   output logic [31:0] oMemWdata,
   output logic        oMemWe,
   output logic        oBusy,
   output logic        oDone,
   output logic        oCrcError
);

   typedef enum logic [3:0] {
      IDLE, RD_NAC, RD_START, RD_DATA, RD_CRC, RD_END,
      WR_WAIT, WR_DATA, WR_CRC, WR_END, WR_GAP, WR_TOKEN, WR_BUSY, WR_RELEASE
   } tState;

   localparam logic [12:0] LAST_BIT  = 13'(32 * DATA_WORDS - 1);
   localparam logic [7:0]  LAST_WORD = 8'(DATA_WORDS - 1);
   localparam logic [15:0] NAC_LAST  = 16'(NAC_CYCLES - 1);
   localparam logic [15:0] BUSY_LAST = 16'(BUSY_CYCLES - 1);

   tState       state;
   logic [12:0] bitCnt;    // data bit currently on the line / being sampled
   logic [15:0] cnt;       // NAC, CRC, token and busy cycle counter
   logic [31:0] shiftReg;
   logic [15:0] crc;       // accumulator, then reused as the CRC shifter on reads
   logic [3:0]  tok;       // remaining token bits after the leading 0
   logic        crcBad;
   logic        tokErr;

   // One step of the serial CRC16 (x^16 + x^12 + x^5 + 1).
   function automatic logic [15:0] crcStep(input logic [15:0] c, input logic b);
      logic fb;
      fb = b ^ c[15];
      return {c[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
   endfunction

   always_ff @(posedge iClock) begin
      if (iReset) begin
         state     <= IDLE;
         oDat      <= 1'b1;
         oDatOe    <= 1'b0;
         oMemAddr  <= 8'd0;
         oMemWdata <= 32'd0;
         oMemWe    <= 1'b0;
         oBusy     <= 1'b0;
         oDone     <= 1'b0;
         oCrcError <= 1'b0;
         bitCnt    <= 13'd0;
         cnt       <= 16'd0;
         shiftReg  <= 32'd0;
         crc       <= 16'd0;
         tok       <= 4'd0;
         crcBad    <= 1'b0;
         tokErr    <= 1'b0;
      end else begin
         oMemWe <= 1'b0;
         oDone  <= 1'b0;
         // Write address advances the cycle after its strobe; the last word keeps its index.
         if (oMemWe && oMemAddr != LAST_WORD)
            oMemAddr <= oMemAddr + 8'd1;

         if (iAbort && state != IDLE) begin
            state    <= IDLE;
            oDatOe   <= 1'b0;
            oDat     <= 1'b1;
            oBusy    <= 1'b0;
            oMemAddr <= 8'd0;
         end else begin
            case (state)
               IDLE: begin
                  if (iStartRead) begin
                     state     <= RD_NAC;
                     oDatOe    <= 1'b1;
                     oDat      <= 1'b1;
                     oBusy     <= 1'b1;
                     cnt       <= 16'd0;
                     oCrcError <= 1'b0;
                  end else if (iStartWrite) begin
                     state     <= WR_WAIT;
                     oBusy     <= 1'b1;
                     oCrcError <= 1'b0;
                  end
               end
               RD_NAC: begin
                  if (cnt == NAC_LAST) begin
                     state <= RD_START;
                     oDat  <= 1'b0;
                  end else begin
                     cnt <= cnt + 16'd1;
                  end
               end
               RD_START: begin
                  state    <= RD_DATA;
                  oDat     <= iMemRdata[31];
                  shiftReg <= {iMemRdata[30:0], 1'b0};
                  crc      <= crcStep(16'h0000, iMemRdata[31]);
                  bitCnt   <= 13'd0;
               end
               RD_DATA: begin
                  bitCnt <= bitCnt + 13'd1;
                  if (bitCnt == LAST_BIT) begin
                     state <= RD_CRC;
                     oDat  <= crc[15];
                     crc   <= {crc[14:0], 1'b0};
                     cnt   <= 16'd0;
                  end else if (bitCnt[4:0] == 5'd31) begin
                     // The address moved on while bit 0 was driven, so the next word is ready.
                     oDat     <= iMemRdata[31];
                     shiftReg <= {iMemRdata[30:0], 1'b0};
                     crc      <= crcStep(crc, iMemRdata[31]);
                  end else begin
                     oDat     <= shiftReg[31];
                     shiftReg <= {shiftReg[30:0], 1'b0};
                     crc      <= crcStep(crc, shiftReg[31]);
                     if (bitCnt[4:0] == 5'd30 && oMemAddr != LAST_WORD)
                        oMemAddr <= oMemAddr + 8'd1;
                  end
               end
               RD_CRC: begin
                  if (cnt == 16'd15) begin
                     state <= RD_END;
                     oDat  <= 1'b1;
                  end else begin
                     oDat <= crc[15];
                     crc  <= {crc[14:0], 1'b0};
                     cnt  <= cnt + 16'd1;
                  end
               end
               RD_END: begin
                  state    <= IDLE;
                  oDatOe   <= 1'b0;
                  oDat     <= 1'b1;
                  oDone    <= 1'b1;
                  oBusy    <= 1'b0;
                  oMemAddr <= 8'd0;
               end
               WR_WAIT: begin
                  if (!iDat) begin
                     state  <= WR_DATA;
                     bitCnt <= 13'd0;
                     crc    <= 16'd0;
                     crcBad <= 1'b0;
                  end
               end
               WR_DATA: begin
                  shiftReg <= {shiftReg[30:0], iDat};
                  crc      <= crcStep(crc, iDat);
                  bitCnt   <= bitCnt + 13'd1;
                  if (bitCnt[4:0] == 5'd31) begin
                     oMemWe    <= 1'b1;
                     oMemWdata <= {shiftReg[30:0], iDat};
                  end
                  if (bitCnt == LAST_BIT) begin
                     state <= WR_CRC;
                     cnt   <= 16'd0;
                  end
               end
               WR_CRC: begin
                  crcBad <= crcBad | (iDat ^ crc[15]);
                  crc    <= {crc[14:0], 1'b0};
                  if (cnt == 16'd15)
                     state <= WR_END;
                  else
                     cnt <= cnt + 16'd1;
               end
               WR_END: begin
                  tokErr    <= crcBad | ~iDat;
                  oCrcError <= crcBad | ~iDat;
                  state     <= WR_GAP;
               end
               WR_GAP: begin
                  state  <= WR_TOKEN;
                  oDatOe <= 1'b1;
                  oDat   <= 1'b0;
                  tok    <= tokErr ? 4'b1011 : 4'b0101;
                  cnt    <= 16'd0;
               end
               WR_TOKEN: begin
                  if (cnt == 16'd4) begin
                     if (tokErr) begin
                        state    <= IDLE;
                        oDatOe   <= 1'b0;
                        oDat     <= 1'b1;
                        oDone    <= 1'b1;
                        oBusy    <= 1'b0;
                        oMemAddr <= 8'd0;
                     end else begin
                        state <= WR_BUSY;
                        oDat  <= 1'b0;
                        cnt   <= 16'd0;
                     end
                  end else begin
                     oDat <= tok[3];
                     tok  <= {tok[2:0], 1'b0};
                     cnt  <= cnt + 16'd1;
                  end
               end
               WR_BUSY: begin
                  if (cnt == BUSY_LAST) begin
                     state <= WR_RELEASE;
                     oDat  <= 1'b1;
                  end else begin
                     cnt <= cnt + 16'd1;
                  end
               end
               WR_RELEASE: begin
                  state    <= IDLE;
                  oDatOe   <= 1'b0;
                  oDat     <= 1'b1;
                  oDone    <= 1'b1;
                  oBusy    <= 1'b0;
                  oMemAddr <= 8'd0;
               end
               default: begin
                  state    <= IDLE;
                  oDatOe   <= 1'b0;
                  oDat     <= 1'b1;
                  oBusy    <= 1'b0;
                  oMemAddr <= 8'd0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_sd_card_dat_responder.sv
// tb/tb_sd_card_dat_responder.sv - self-checking bench for sd_card_dat_responder
module tb_sd_card_dat_responder;

   localparam int NAC  = 2;
   localparam int BUSY = 8;

   logic        iClock = 1'b0;
   logic        iReset;
   logic        startRead  [2];
   logic        startWrite [2];
   logic        abortReq   [2];
   logic        datIn      [2];
   logic        oDat       [2];
   logic        oDatOe     [2];
   logic [7:0]  memAddr    [2];
   logic [31:0] memRdata   [2];
   logic [31:0] memWdata   [2];
   logic        oMemWe     [2];
   logic        oBusy      [2];
   logic        oDone      [2];
   logic        oCrcError  [2];
   logic [31:0] mem [2][4];

   int nAssert = 0;
   int nFail   = 0;
   int cyc     = 0;
   int weAddrQ[$];
   logic [31:0] weDataQ[$];
   int weCycQ[$];

   always #5 iClock = ~iClock;
   always @(posedge iClock) cyc <= cyc + 1;

   assign memRdata[0] = mem[0][memAddr[0][1:0]];
   assign memRdata[1] = mem[1][memAddr[1][1:0]];

   sd_card_dat_responder #(.DATA_WORDS(1), .BUSY_CYCLES(BUSY), .NAC_CYCLES(NAC)) u0 (
      .iClock(iClock), .iReset(iReset), .iStartRead(startRead[0]), .iStartWrite(startWrite[0]),
      .iAbort(abortReq[0]), .iDat(datIn[0]), .oDat(oDat[0]), .oDatOe(oDatOe[0]),
      .oMemAddr(memAddr[0]), .iMemRdata(memRdata[0]), .oMemWdata(memWdata[0]), .oMemWe(oMemWe[0]),
      .oBusy(oBusy[0]), .oDone(oDone[0]), .oCrcError(oCrcError[0]));

   sd_card_dat_responder #(.DATA_WORDS(2), .BUSY_CYCLES(BUSY), .NAC_CYCLES(NAC)) u1 (
      .iClock(iClock), .iReset(iReset), .iStartRead(startRead[1]), .iStartWrite(startWrite[1]),
      .iAbort(abortReq[1]), .iDat(datIn[1]), .oDat(oDat[1]), .oDatOe(oDatOe[1]),
      .oMemAddr(memAddr[1]), .iMemRdata(memRdata[1]), .oMemWdata(memWdata[1]), .oMemWe(oMemWe[1]),
      .oBusy(oBusy[1]), .oDone(oDone[1]), .oCrcError(oCrcError[1]));

   // Record every write strobe of the two-word card with its cycle number.
   always @(negedge iClock) begin
      if (oMemWe[1] === 1'b1) begin
         weAddrQ.push_back(int'(memAddr[1]));
         weDataQ.push_back(memWdata[1]);
         weCycQ.push_back(cyc);
      end
   end

   task automatic tick;
      @(negedge iClock);
   endtask

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      nAssert++;
      assert (obs === exp) else begin
         nFail++;
         $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
      end
   endtask

   // CRC16 as the remainder of M(x)*x^16 divided by x^16+x^12+x^5+1.
   function automatic logic [15:0] crcRef(input bit msg[$]);
      bit r[$];
      logic [16:0] g;
      logic [15:0] rem;
      g = 17'h11021;
      r = msg;
      repeat (16) r.push_back(1'b0);
      for (int i = 0; i < msg.size(); i++)
         if (r[i])
            for (int j = 0; j < 17; j++) r[i + j] = r[i + j] ^ g[16 - j];
      for (int j = 0; j < 16; j++) rem[15 - j] = r[msg.size() + j];
      return rem;
   endfunction

   function automatic logic [127:0] pack(input bit q[$]);
      logic [127:0] v;
      v = '0;
      foreach (q[k]) v = {v[126:0], q[k]};
      return v;
   endfunction

   task automatic checkResetState(input int i, input string tag);
      check(tag, 128'({oDat[i], oDatOe[i], memAddr[i], memWdata[i], oMemWe[i], oBusy[i], oDone[i], oCrcError[i]}),
            128'({1'b1, 1'b0, 8'h00, 32'h0, 4'h0}));
   endtask

   task automatic runRead(input int i, input int dw, input bit bothStarts, input int midWrite);
      bit data[$], expQ[$], gotQ[$];
      logic [15:0] c;
      int oeBad;
      oeBad = 0;
      for (int w = 0; w < dw; w++)
         for (int b = 31; b >= 0; b--) data.push_back(mem[i][w][b]);
      c = crcRef(data);
      repeat (NAC) expQ.push_back(1'b1);
      expQ.push_back(1'b0);
      foreach (data[k]) expQ.push_back(data[k]);
      for (int b = 15; b >= 0; b--) expQ.push_back(c[b]);
      expQ.push_back(1'b1);

      startRead[i] = 1'b1;
      startWrite[i] = bothStarts;
      tick;
      startRead[i] = 1'b0;
      startWrite[i] = 1'b0;
      check("rd_crcerr_cleared", 128'(oCrcError[i]), 128'(0));
      for (int k = 0; k < expQ.size(); k++) begin
         if (oDatOe[i] !== 1'b1) oeBad++;
         gotQ.push_back(oDat[i]);
         startWrite[i] = (k == midWrite);
         tick;
      end
      startWrite[i] = 1'b0;
      check("rd_stream", pack(gotQ), pack(expQ));
      check("rd_oe_during", 128'(oeBad), 128'(0));
      check("rd_done", 128'({oDone[i], oDatOe[i], oDat[i]}), 128'(3'b101));
      tick;
      check("rd_done_pulse_idle", 128'({oDone[i], oBusy[i]}), 128'(2'b00));
   endtask

   task automatic runWrite(input logic [31:0] w0, input logic [31:0] w1, input bit flipCrc, input bit badEnd);
      bit data[$], expQ[$], gotQ[$];
      logic [15:0] sent;
      logic [31:0] words [2];
      int fb, cS, oeBad;
      bit good;
      words[0] = w0;
      words[1] = w1;
      oeBad = 0;
      for (int w = 0; w < 2; w++)
         for (int b = 31; b >= 0; b--) data.push_back(words[w][b]);
      sent = crcRef(data);
      if (flipCrc) begin
         fb = $urandom_range(15, 0);
         sent[fb] = ~sent[fb];
      end
      good = !flipCrc && !badEnd;
      expQ.push_back(1'b0);
      if (good) begin
         expQ.push_back(1'b0); expQ.push_back(1'b1); expQ.push_back(1'b0);
      end else begin
         expQ.push_back(1'b1); expQ.push_back(1'b0); expQ.push_back(1'b1);
      end
      expQ.push_back(1'b1);
      if (good) begin
         repeat (BUSY) expQ.push_back(1'b0);
         expQ.push_back(1'b1);
      end
      weAddrQ.delete();
      weDataQ.delete();
      weCycQ.delete();

      startWrite[1] = 1'b1;
      tick;
      startWrite[1] = 1'b0;
      check("wr_armed", 128'({oBusy[1], oDatOe[1]}), 128'(2'b10));
      repeat ($urandom_range(4, 1)) tick;
      datIn[1] = 1'b0;
      tick;
      cS = cyc;
      foreach (data[k]) begin
         datIn[1] = data[k];
         tick;
      end
      for (int b = 15; b >= 0; b--) begin
         datIn[1] = sent[b];
         tick;
      end
      datIn[1] = !badEnd;
      tick;
      datIn[1] = 1'b1;
      check("wr_gap_released", 128'(oDatOe[1]), 128'(0));
      tick;
      for (int k = 0; k < expQ.size(); k++) begin
         if (oDatOe[1] !== 1'b1) oeBad++;
         gotQ.push_back(oDat[1]);
         tick;
      end
      check("wr_token_busy", pack(gotQ), pack(expQ));
      check("wr_oe_during", 128'(oeBad), 128'(0));
      check("wr_done", 128'({oDone[1], oDatOe[1], oCrcError[1]}), 128'({2'b10, !good}));
      check("wr_we_count", 128'(weAddrQ.size()), 128'(2));
      if (weAddrQ.size() == 2) begin
         check("wr_we_addr", 128'({weAddrQ[0], weAddrQ[1]}), 128'({32'd0, 32'd1}));
         check("wr_we_data", 128'({weDataQ[0], weDataQ[1]}), 128'({w0, w1}));
         check("wr_we_cycle", 128'({weCycQ[0] - cS, weCycQ[1] - cS}), 128'({32'd32, 32'd64}));
      end
      tick;
      check("wr_done_pulse", 128'(oDone[1]), 128'(0));
   endtask

   initial begin
      int doneSeen;
      iReset = 1'b1;
      for (int i = 0; i < 2; i++) begin
         startRead[i] = 1'b0;
         startWrite[i] = 1'b0;
         abortReq[i] = 1'b0;
         datIn[i] = 1'b1;
         for (int w = 0; w < 4; w++) mem[i][w] = $urandom;
      end
      mem[0][0] = 32'hA5A5_0F0F;
      repeat (3) tick;
      checkResetState(0, "reset_state_u0");
      checkResetState(1, "reset_state_u1");
      iReset = 1'b0;
      tick;

      runRead(0, 1, 1'b0, -1);
      runWrite(32'h1234_5678, 32'hDEAD_BEEF, 1'b0, 1'b0);
      runWrite($urandom, $urandom, 1'b1, 1'b0);
      check("crc_error_sticky", 128'(oCrcError[1]), 128'(1));
      runRead(1, 2, 1'b0, -1);
      runWrite($urandom, $urandom, 1'b0, 1'b1);
      runRead(1, 2, 1'b1, -1);
      runRead(1, 2, 1'b0, 20);

      repeat (3) begin
         mem[1][0] = $urandom;
         mem[1][1] = $urandom;
         runRead(1, 2, 1'($urandom_range(1, 0)), int'($urandom_range(70, 0)));
         runWrite($urandom, $urandom, 1'($urandom_range(1, 0)), 1'b0);
      end

      // Abort while data bit 10 is on the line.
      startRead[1] = 1'b1;
      tick;
      startRead[1] = 1'b0;
      repeat (NAC + 1 + 10) tick;
      abortReq[1] = 1'b1;
      tick;
      abortReq[1] = 1'b0;
      check("abort_idle", 128'({oDatOe[1], oDat[1], oBusy[1], oDone[1], memAddr[1]}), 128'({4'b0100, 8'h00}));
      doneSeen = 0;
      repeat (80) begin
         if (oDone[1] === 1'b1) doneSeen++;
         tick;
      end
      check("abort_no_done", 128'(doneSeen), 128'(0));

      // Reset after the first word of a write has been stored.
      weAddrQ.delete();
      startWrite[1] = 1'b1;
      tick;
      startWrite[1] = 1'b0;
      datIn[1] = 1'b0;
      tick;
      repeat (40) begin
         datIn[1] = 1'($urandom_range(1, 0));
         tick;
      end
      iReset = 1'b1;
      tick;
      checkResetState(1, "reset_mid_write");
      iReset = 1'b0;
      repeat (60) begin
         datIn[1] = 1'($urandom_range(1, 0));
         tick;
      end
      check("reset_no_more_we", 128'(weAddrQ.size()), 128'(1));
      check("reset_stays_idle", 128'({oBusy[1], oDatOe[1]}), 128'(2'b00));

      $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
      $finish;
   end

endmodule
